tx_scale_sat: RTL

//  Transmit-path sample formatter; counterpart of the receive-side round/saturate stage.

---
 rtl/tx_fmt_pkg.sv | 22 ++
 rtl/tx_sat_round.sv | 37 +++
 rtl/tx_scale_sat.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tx_fmt_pkg.sv
// Shared definitions for the TX sample formatter: DAC limit helpers,
// the product-width helper and the dither LFSR constants (TX_DITHER_EN).
package tx_fmt_pkg;

  // 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1: tap mask on bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int out_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int out_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // Full-precision width of signed sample times zero-extended unsigned gain
  function automatic int prod_width(input int in_w, input int g_w);
    return in_w + g_w + 1;
  endfunction

endpackage

// File: rtl/tx_sat_round.sv
// Combinational round-and-clip: adds the rounding offset to the product,
// arithmetic-shifts out the gain fraction and clips to the DAC range.
module tx_sat_round
  import tx_fmt_pkg::*;
#(
  parameter int PROD_W = 23,
  parameter int FRAC   = 8,
  parameter int OUT_W  = 12
) (
  input  logic signed [PROD_W-1:0] p_i,
  input  logic        [FRAC-1:0]   offset_i,
  output logic                     sat_o,
  output logic        [OUT_W-1:0]  value_o
);

  logic signed [PROD_W:0]      sum;
  logic signed [PROD_W:0]      shifted;
  logic        [PROD_W-OUT_W+1:0] hi;
  logic                        in_range;

  // One extra bit of headroom keeps the offset add from overflowing
  always_comb begin
    sum      = {p_i[PROD_W-1], p_i} + {{(PROD_W + 1 - FRAC){1'b0}}, offset_i};
    shifted  = sum >>> FRAC;
    hi       = shifted[PROD_W:OUT_W-1];
    in_range = (&hi) | ~(|hi);
    sat_o    = ~in_range;
    if (in_range) begin
      value_o = shifted[OUT_W-1:0];
    end else if (shifted[PROD_W]) begin
      value_o = OUT_W'(out_min(OUT_W));
    end else begin
      value_o = OUT_W'(out_max(OUT_W));
    end
  end

endmodule

// File: rtl/tx_scale_sat.sv
// TX sample formatter: signed sample x unsigned fixed-point gain, rounded
// and saturated to DAC width through a two-stage valid/ready pipeline.
// Optional feature macro: TX_DITHER_EN (LFSR rounding offset).
module tx_scale_sat
  import tx_fmt_pkg::*;
#(
  parameter int IN_WIDTH   = 12,
  parameter int GAIN_WIDTH = 10,
  parameter int GAIN_FRAC  = 8,
  parameter int OUT_WIDTH  = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [GAIN_WIDTH-1:0] GAIN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [IN_WIDTH-1:0]   DATA_IN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [OUT_WIDTH-1:0]  DATA_OUT,
  output logic                  SAT_FLAG,
  output logic [CNT_WIDTH-1:0]  SAT_CNT,
  input  logic                  CNT_CLR
);

  localparam int PW = prod_width(IN_WIDTH, GAIN_WIDTH);

  logic                 s2_en, s1_en, in_hs, out_hs;
  logic                 s1_valid_q, s1_valid_d;
  logic signed [PW-1:0] p_q, p_d;
  logic [GAIN_FRAC-1:0] off_s2;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                 sat_flag_q, sat_flag_d;
  logic [CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;
  logic                 rs_sat;
  logic [OUT_WIDTH-1:0] rs_value;

  // Pipeline enables; OUT_READY reaches IN_READY combinationally
  always_comb begin
    s2_en  = ~out_valid_q | OUT_READY;
    s1_en  = ~s1_valid_q | s2_en;
    in_hs  = IN_VALID & s1_en;
    out_hs = out_valid_q & OUT_READY;
  end

  // Stage 1: capture the full-precision product on input handshake
  always_comb begin
    s1_valid_d = s1_en ? IN_VALID : s1_valid_q;
    p_d        = p_q;
    if (in_hs) begin
      p_d = PW'($signed(DATA_IN)) * PW'($signed({1'b0, GAIN}));
    end
  end

`ifdef TX_DITHER_EN
  logic [15:0]          lfsr_q, lfsr_d;
  logic [GAIN_FRAC-1:0] off_q, off_d;

  // Dither LFSR advances per accepted sample; its pre-advance value travels with P
  always_comb begin
    lfsr_d = lfsr_q;
    off_d  = off_q;
    if (in_hs) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      off_d  = lfsr_q[GAIN_FRAC-1:0];
    end
  end

  // Dither state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q <= LFSR_SEED;
      off_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      off_q  <= off_d;
    end
  end

  assign off_s2 = off_q;
`else
  assign off_s2 = GAIN_FRAC'(1) << (GAIN_FRAC - 1);
`endif

  tx_sat_round #(
    .PROD_W (PW),
    .FRAC   (GAIN_FRAC),
    .OUT_W  (OUT_WIDTH)
  ) u_sat_round (
    .p_i      (p_q),
    .offset_i (off_s2),
    .sat_o    (rs_sat),
    .value_o  (rs_value)
  );

  // Stage 2: load rounded/clipped result when the output slot frees up
  always_comb begin
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    sat_flag_d  = sat_flag_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_out_d = rs_value;
        sat_flag_d = rs_sat;
      end
    end
  end

  // Saturation-event counter: sticky at all-ones, clear has priority
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (CNT_CLR) begin
      sat_cnt_d = '0;
    end else if (out_hs && sat_flag_q && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  // Pipeline and counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      sat_flag_q  <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      sat_flag_q  <= sat_flag_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign IN_READY  = s1_en;
  assign OUT_VALID = out_valid_q;
  assign DATA_OUT  = data_out_q;
  assign SAT_FLAG  = sat_flag_q;
  assign SAT_CNT   = sat_cnt_q;

endmodule
